// File: rtl/menu_selector_if.sv
// Button/menu bus between the board-side button pins, the game FSM and the
// menu selector. Master is the game/board side, slave is the selector.
interface menu_selector_if;
  logic       i_enable;
  logic       i_btn_left;
  logic       i_btn_right;
  logic       i_btn_confirm;
  logic [1:0] o_cursor_position;
  logic       o_menu_active;
  logic       o_select_valid;
  logic [1:0] o_select_item;

  modport master (
    output i_enable, i_btn_left, i_btn_right, i_btn_confirm,
    input  o_cursor_position, o_menu_active, o_select_valid, o_select_item
  );

  modport slave (
    input  i_enable, i_btn_left, i_btn_right, i_btn_confirm,
    output o_cursor_position, o_menu_active, o_select_valid, o_select_item
  );
endinterface

// File: rtl/menu_selector.sv
// Battle-menu selector: synchronises and debounces LEFT/RIGHT/CONFIRM,
// moves a 2-bit cursor index (FIGHT/ACT/ITEM/MERCY) and reports the
// confirmed choice once per menu entry.
//
// state      | meaning
// -----------+-------------------------------------------------------
// S_DISABLED | menu phase inactive, button events ignored
// S_NAV      | cursor follows left/right events, waiting for confirm
// S_LOCK     | choice confirmed, everything ignored until disable
module menu_selector #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int WRAP            = 1,
  parameter int RESET_ON_ENTER  = 1
) (
  input logic       i_clk,
  input logic       i_rst_n,
  menu_selector_if.slave bus
);

  localparam int            CW     = $clog2(DEBOUNCE_CYCLES + 1);
  // Level flips on the cycle the count would reach DEBOUNCE_CYCLES.
  localparam logic [CW-1:0] CNT_TC = CW'(DEBOUNCE_CYCLES - 1);

  localparam int BTN_L = 0;
  localparam int BTN_R = 1;
  localparam int BTN_C = 2;

  typedef enum logic [1:0] {
    S_DISABLED = 2'd0,
    S_NAV      = 2'd1,
    S_LOCK     = 2'd2
  } state_t;

  logic [2:0]    w_raw;
  logic [2:0]    r_sync1;
  logic [2:0]    r_sync2;
  logic [2:0]    r_deb;
  logic [2:0]    r_deb_d;
  logic [2:0]    r_evt;
  logic [CW-1:0] r_cnt [3];

  state_t     r_state;
  state_t     w_state_nxt;
  logic [1:0] r_index;
  logic [1:0] w_index_nxt;
  logic [1:0] r_sel_item;
  logic [1:0] w_sel_item_nxt;
  logic       r_sel_valid;
  logic       w_sel_valid_nxt;

  assign w_raw = {bus.i_btn_confirm, bus.i_btn_right, bus.i_btn_left};

  // Two-flop synchronizer for the asynchronous button pins.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= w_raw;
      r_sync2 <= r_sync1;
    end
  end

  // Debounce: accept a new level only after it is stable DEBOUNCE_CYCLES samples.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_deb <= '0;
      for (int i = 0; i < 3; i++) r_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (r_sync2[i] == r_deb[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] == CNT_TC) begin
          r_cnt[i] <= '0;
          r_deb[i] <= r_sync2[i];
        end else begin
          r_cnt[i] <= r_cnt[i] + 1'b1;
        end
      end
    end
  end

  // Registered one-cycle press event on each debounced rising edge.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_deb_d <= '0;
      r_evt   <= '0;
    end else begin
      r_deb_d <= r_deb;
      r_evt   <= r_deb & ~r_deb_d;
    end
  end

  // FSM state and registered outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= S_DISABLED;
      r_index     <= 2'd0;
      r_sel_item  <= 2'd0;
      r_sel_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_index     <= w_index_nxt;
      r_sel_item  <= w_sel_item_nxt;
      r_sel_valid <= w_sel_valid_nxt;
    end
  end

  // Next-state, cursor movement and confirm capture.
  always_comb begin
    w_state_nxt     = r_state;
    w_index_nxt     = r_index;
    w_sel_item_nxt  = r_sel_item;
    w_sel_valid_nxt = 1'b0;
    unique case (r_state)
      S_DISABLED: begin
        if (bus.i_enable) begin
          w_state_nxt = S_NAV;
          if (RESET_ON_ENTER != 0) w_index_nxt = 2'd0;
        end
      end
      S_NAV: begin
        if (!bus.i_enable) begin
          w_state_nxt = S_DISABLED;
        end else if (r_evt[BTN_C]) begin
          // Confirm wins over a simultaneous move; index stays put.
          w_state_nxt     = S_LOCK;
          w_sel_item_nxt  = r_index;
          w_sel_valid_nxt = 1'b1;
        end else if (r_evt[BTN_L] && r_evt[BTN_R]) begin
          w_index_nxt = r_index;
        end else if (r_evt[BTN_R]) begin
          if (r_index == 2'd3 && WRAP == 0) w_index_nxt = r_index;
          else                              w_index_nxt = r_index + 2'd1;
        end else if (r_evt[BTN_L]) begin
          if (r_index == 2'd0 && WRAP == 0) w_index_nxt = r_index;
          else                              w_index_nxt = r_index - 2'd1;
        end
      end
      S_LOCK: begin
        if (!bus.i_enable) w_state_nxt = S_DISABLED;
      end
      default: begin
        w_state_nxt = S_DISABLED;
      end
    endcase
  end

  assign bus.o_cursor_position = r_index;
  assign bus.o_menu_active     = (r_state == S_NAV);
  assign bus.o_select_valid    = r_sel_valid;
  assign bus.o_select_item     = r_sel_item;

endmodule

// File: tb/tb_menu_selector.sv
// Bench for menu_selector: two instances (wrap + reset-on-entry, and
// saturate + retain) driven by the same buttons and compared every cycle
// against a behavioural model, plus directed boundary checks.
module tb_menu_selector;
  localparam int DEB = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  bit   rst_req = 1'b1;

  always #5 clk = ~clk;

  menu_selector_if bus_a ();
  menu_selector_if bus_b ();

  menu_selector #(.DEBOUNCE_CYCLES(DEB), .WRAP(1), .RESET_ON_ENTER(1)) dut_a (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus_a)
  );

  menu_selector #(.DEBOUNCE_CYCLES(DEB), .WRAP(0), .RESET_ON_ENTER(0)) dut_b (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus_b)
  );

  int errors   = 0;
  int checks   = 0;
  int pulses_a = 0;

  // Current stimulus levels (button index: 0 left, 1 right, 2 confirm)
  bit cur_en;
  bit cur_btn [3];
  bit en_lvl;

  // Model: per-button input path described as "level accepted after DEB
  // identical samples, seen two cycles late, event two cycles after that"
  bit m_p1 [3];
  bit m_p2 [3];
  bit m_last [3];
  int m_run [3];
  bit m_deb [3];
  bit m_rose [3];
  bit m_evt [3];

  // Model: per-instance menu behaviour
  bit       m_wrap [2];
  bit       m_roe  [2];
  bit       m_nav  [2];
  bit       m_lock [2];
  bit       m_valid[2];
  bit [1:0] m_pos  [2];
  bit [1:0] m_item [2];

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int b = 0; b < 3; b++) begin
      m_p1[b] = 0; m_p2[b] = 0; m_last[b] = 0; m_run[b] = 0;
      m_deb[b] = 0; m_rose[b] = 0; m_evt[b] = 0;
    end
    for (int d = 0; d < 2; d++) begin
      m_nav[d] = 0; m_lock[d] = 0; m_valid[d] = 0; m_pos[d] = 0; m_item[d] = 0;
    end
  endtask

  task automatic model_step();
    bit ev [3];
    bit s;
    bit rose;
    for (int b = 0; b < 3; b++) ev[b] = m_evt[b];
    for (int d = 0; d < 2; d++) begin
      m_valid[d] = 0;
      if (m_nav[d]) begin
        if (!cur_en) begin
          m_nav[d] = 0;
        end else if (ev[2]) begin
          m_item[d] = m_pos[d]; m_valid[d] = 1; m_nav[d] = 0; m_lock[d] = 1;
        end else if (ev[0] && ev[1]) begin
          m_pos[d] = m_pos[d];
        end else if (ev[1]) begin
          if (m_pos[d] == 2'd3) m_pos[d] = m_wrap[d] ? 2'd0 : 2'd3;
          else                  m_pos[d] = m_pos[d] + 2'd1;
        end else if (ev[0]) begin
          if (m_pos[d] == 2'd0) m_pos[d] = m_wrap[d] ? 2'd3 : 2'd0;
          else                  m_pos[d] = m_pos[d] - 2'd1;
        end
      end else if (m_lock[d]) begin
        if (!cur_en) m_lock[d] = 0;
      end else if (cur_en) begin
        m_nav[d] = 1;
        if (m_roe[d]) m_pos[d] = 2'd0;
      end
    end
    for (int b = 0; b < 3; b++) begin
      s = m_p2[b];
      m_p2[b] = m_p1[b];
      m_p1[b] = cur_btn[b];
      if (s == m_last[b]) begin
        if (m_run[b] < 1000) m_run[b]++;
      end else begin
        m_run[b] = 1;
      end
      m_last[b] = s;
      rose = 0;
      if (s != m_deb[b] && m_run[b] >= DEB) begin
        m_deb[b] = s;
        rose = s;
      end
      m_evt[b]  = m_rose[b];
      m_rose[b] = rose;
    end
  endtask

  task automatic compare_all();
    check_val("a_pos",    bus_a.o_cursor_position, m_pos[0]);
    check_val("a_active", bus_a.o_menu_active,     m_nav[0]);
    check_val("a_valid",  bus_a.o_select_valid,    m_valid[0]);
    check_val("a_item",   bus_a.o_select_item,     m_item[0]);
    check_val("b_pos",    bus_b.o_cursor_position, m_pos[1]);
    check_val("b_active", bus_b.o_menu_active,     m_nav[1]);
    check_val("b_valid",  bus_b.o_select_valid,    m_valid[1]);
    check_val("b_item",   bus_b.o_select_item,     m_item[1]);
    if (bus_a.o_select_valid === 1'b1) pulses_a++;
  endtask

  task automatic drive(input bit en, input bit l, input bit r, input bit c);
    cur_en = en; cur_btn[0] = l; cur_btn[1] = r; cur_btn[2] = c;
    bus_a.i_enable = en; bus_a.i_btn_left = l; bus_a.i_btn_right = r; bus_a.i_btn_confirm = c;
    bus_b.i_enable = en; bus_b.i_btn_left = l; bus_b.i_btn_right = r; bus_b.i_btn_confirm = c;
  endtask

  // One clock: check at negedge, drive, model the posedge; returns 1 after it.
  task automatic step(input bit l, input bit r, input bit c);
    @(negedge clk);
    compare_all();
    drive(en_lvl, l, r, c);
    rst_n = !rst_req;
    @(posedge clk);
    if (rst_n) model_step();
    else       model_reset();
    #1;
  endtask

  task automatic press(input bit l, input bit r, input bit c, input int hold, input int rel);
    for (int i = 0; i < hold; i++) step(l, r, c);
    for (int i = 0; i < rel; i++)  step(0, 0, 0);
  endtask

  task automatic async_reset();
    @(negedge clk);
    compare_all();
    #2;
    rst_req = 1;
    rst_n   = 1'b0;
    #1;
    check_val("rst_a_pos",    bus_a.o_cursor_position, 0);
    check_val("rst_b_pos",    bus_b.o_cursor_position, 0);
    check_val("rst_a_active", bus_a.o_menu_active,     0);
    check_val("rst_b_item",   bus_b.o_select_item,     0);
    check_val("rst_a_valid",  bus_a.o_select_valid,    0);
    model_reset();
    @(posedge clk);
    model_reset();
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int hold;
    m_wrap[0] = 1; m_roe[0] = 1;
    m_wrap[1] = 0; m_roe[1] = 0;
    model_reset();
    en_lvl = 0;
    drive(0, 0, 0, 0);

    // Reset, then enter the menu
    for (int i = 0; i < 3; i++) step(0, 0, 0);
    rst_req = 0;
    en_lvl  = 1;
    for (int i = 0; i < 3; i++) step(0, 0, 0);

    // Press-to-move latency
    lat = -1;
    for (int i = 0; i < 20; i++) begin
      step(0, 1, 0);
      if (lat < 0 && bus_a.o_cursor_position == 2'd1) lat = i;
    end
    check_val("latency", lat, 7);
    press(0, 0, 0, 0, 8);
    check_val("a_pos_1", bus_a.o_cursor_position, 1);

    // Three more rights: wrap on A, saturate on B
    for (int k = 0; k < 3; k++) press(0, 1, 0, 8, 8);
    check_val("a_wrap_to_0", bus_a.o_cursor_position, 0);
    check_val("b_sat_at_3",  bus_b.o_cursor_position, 3);

    // Reset mid-count with right held; held button must not produce an event
    press(0, 1, 0, 3, 0);
    async_reset();
    for (int i = 0; i < 2; i++) step(0, 1, 0);
    rst_req = 0;
    en_lvl  = 0;
    for (int i = 0; i < 10; i++) step(0, 1, 0);
    en_lvl = 1;
    press(0, 1, 0, 6, 8);
    check_val("held_a_pos", bus_a.o_cursor_position, 0);
    check_val("held_b_pos", bus_b.o_cursor_position, 0);

    // Left from 0: wrap on A, saturate on B
    press(1, 0, 0, 8, 8);
    check_val("a_wrap_to_3", bus_a.o_cursor_position, 3);
    check_val("b_sat_at_0",  bus_b.o_cursor_position, 0);

    // Short glitch: no change; bounce then stable: exactly one step
    press(0, 1, 0, 3, 8);
    check_val("glitch_a", bus_a.o_cursor_position, 3);
    step(0, 1, 0); step(0, 0, 0); step(0, 1, 0);
    press(0, 1, 0, 8, 8);
    check_val("bounce_a", bus_a.o_cursor_position, 0);
    check_val("bounce_b", bus_b.o_cursor_position, 1);

    // Move A to 2 (B to 3), then confirm + right on the same edge
    press(0, 1, 0, 8, 8);
    press(0, 1, 0, 8, 8);
    pulses_a = 0;
    press(0, 1, 1, 8, 8);
    check_val("confirm_pulses", pulses_a, 1);
    check_val("confirm_item_a", bus_a.o_select_item, 2);
    check_val("confirm_pos_a",  bus_a.o_cursor_position, 2);
    check_val("confirm_item_b", bus_b.o_select_item, 3);

    // LOCK ignores everything
    press(0, 1, 0, 8, 8);
    press(0, 0, 1, 8, 8);
    check_val("lock_pos_a",    bus_a.o_cursor_position, 2);
    check_val("lock_pulses_a", pulses_a, 1);

    // Re-entry, then left+right together
    en_lvl = 0;
    press(0, 0, 0, 0, 3);
    en_lvl = 1;
    press(0, 0, 0, 0, 3);
    check_val("reenter_a", bus_a.o_cursor_position, 0);
    check_val("reenter_b", bus_b.o_cursor_position, 3);
    press(1, 1, 0, 8, 8);
    check_val("lr_a", bus_a.o_cursor_position, 0);
    check_val("lr_b", bus_b.o_cursor_position, 3);

    // Randomized buttons and enable, checked every cycle against the model
    for (int seg = 0; seg < 1500; seg++) begin
      bit l;
      bit r;
      bit c;
      if ($urandom_range(0, 15) == 0) en_lvl = !en_lvl;
      l = ($urandom_range(0, 2) == 0);
      r = ($urandom_range(0, 2) == 0);
      c = ($urandom_range(0, 7) == 0);
      hold = $urandom_range(1, 10);
      for (int i = 0; i < hold; i++) step(l, r, c);
    end
    step(0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
